rsa_modmul: RTL
===============

RSA_MODMUL -- requirements
Module: rsa_modmul

Interface
REQ-001 Parameter: WIDTH, default 16, operand/modulus width in bits, legal range 4..64.
REQ-002 clk  input  1  rising-edge clock; sole clock of the block.
REQ-003 rst_n  input  1  reset; synchronous and active-low.
REQ-004 start  input  1  request pulse from the binary exponentiation controller; level sampled each edge.
REQ-005 a  input  WIDTH  multiplicand; sampled only on the accepting edge.
REQ-006 b  input  WIDTH  multiplier; sampled only on the accepting edge.
REQ-007 n  input  WIDTH  modulus; sampled only on the accepting edge.
REQ-008 result  output  WIDTH  (a*b) mod n; registered.
REQ-009 busy  output  1  high while iterating.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 err  output  1  operand fault; valid while done is high.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-013 An accepting edge SHALL be a rising edge with state==IDLE and start==1; start SHALL be ignored in CALC and DONE.
REQ-014 On the accepting edge the block SHALL:
- latch a, b and n;
- clear accumulator P to 0;
- load the bit counter with WIDTH-1;
- set the fault flag to (n==0) or (a>=n);
- go to CALC.
REQ-015 Each CALC edge SHALL process latched bit b[cnt] MSB-first:
- T = 2P; if T>=n, T = T-n;
- if b[cnt]==1: T = T+a; if T>=n, T = T-n;
- P = T.
REQ-016 Intermediate sums SHALL be WIDTH+1 bits wide; no bit SHALL be lost at 2P or P+a.
REQ-017 In CALC, an edge with cnt==0 SHALL go to DONE; otherwise cnt SHALL decrement.
REQ-018 The counter SHALL never wrap.
REQ-019 Exactly WIDTH CALC edges SHALL occur per operation.
REQ-020 In DONE the block SHALL:
- assert done=1 for exactly one cycle;
- set result=P, or result=0 if the fault flag is set;
- set err equal to the fault flag;
- return to IDLE on the next edge.
REQ-021 Latency: if start is high in cycle k (IDLE), busy SHALL be 1 in cycles k+1..k+WIDTH and done SHALL be 1 in cycle k+WIDTH+1.
REQ-022 A new start SHALL be accepted no earlier than cycle k+WIDTH+2, giving back-to-back throughput of one operation per WIDTH+2 cycles.
REQ-023 result SHALL hold its value from DONE until the next DONE and SHALL NOT change during CALC.
REQ-024 err SHALL hold its value until the next DONE.
REQ-025 busy and done SHALL never be high in the same cycle.
REQ-026 With the fault flag set, iteration SHALL still run WIDTH cycles; latency SHALL be identical to the fault-free case.
REQ-027 Changes on a, b or n after the accepting edge SHALL NOT affect the operation in progress.

Reset
REQ-028 On any edge with rst_n==0 the block SHALL reach this state, regardless of current state:
- state=IDLE, P=0, cnt=0, fault flag=0;
- result=0, busy=0, done=0, err=0.
REQ-029 Reset during CALC or DONE SHALL abort the operation with no done pulse.
REQ-030 start high on the first edge with rst_n==1 SHALL be accepted.
REQ-031 While rst_n==0, start SHALL be ignored.

Verification (WIDTH=16)
REQ-032 Basic operation:
- stimulus: a=7, b=9, n=11, start high in cycle 0;
- required response: busy=1 in cycles 1..16, done=1 in cycle 17 only, result=8, err=0.
REQ-033 Boundary values:
- stimulus: a=65520, b=65520, n=65521;
- required response: result=1, err=0.
- stimulus: a=1234, b=0, n=4001;
- required response: result=0, err=0.
REQ-034 Faults:
- stimulus: n=0, a=5, b=3;
- required response: done in cycle 17, result=0, err=1.
- stimulus: a=20, b=2, n=11;
- required response: done in cycle 17, result=0, err=1.
REQ-035 Start while busy:
- stimulus: start held high from cycle 0 through cycle 20;
- required response: exactly one done (cycle 17); second operation accepted at end of cycle 18, busy again in cycle 19.
- stimulus: a/b/n changed in cycle 5;
- required response: result unaffected.
REQ-036 Reset mid-operation:
- stimulus: rst_n=0 in cycle 8 of an operation;
- required response: busy=0 from cycle 9, no done pulse, result=0, err=0.
- stimulus: rst_n released, then start with a=3, b=5, n=7;
- required response: result=1 after 17 cycles.

Source files
------------

// File: rtl/rsa_modmul.sv
// Modular multiplier (a*b) mod n by MSB-first shift-and-add with conditional subtraction.
// One bit per cycle: WIDTH CALC cycles plus one DONE cycle; start is ignored while not IDLE.
module rsa_modmul #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fault_q, fault_d;
    logic             err_q, err_d;

    logic [WIDTH:0]   dbl, dbl_r, sum, sum_r;
    logic [WIDTH-1:0] step;

    // One iteration; the extra top bit keeps the carry of 2P and T+a.
    always_comb begin
        dbl   = {p_q, 1'b0};
        dbl_r = (dbl >= {1'b0, n_q}) ? (dbl - {1'b0, n_q}) : dbl;
        sum   = {1'b0, dbl_r[WIDTH-1:0]} + {1'b0, a_q};
        sum_r = (sum >= {1'b0, n_q}) ? (sum - {1'b0, n_q}) : sum;
        step  = b_q[cnt_q] ? sum_r[WIDTH-1:0] : dbl_r[WIDTH-1:0];
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        n_d      = n_q;
        p_d      = p_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        fault_d  = fault_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    n_d     = n;
                    p_d     = '0;
                    cnt_d   = CW'(WIDTH - 1);
                    fault_d = (n == '0) || (a >= n);
                    state_d = CALC;
                end
            end
            CALC: begin
                p_d = step;
                if (cnt_q == '0) begin
                    // Publish on the way into DONE so result/err are valid with the pulse.
                    result_d = fault_q ? '0 : step;
                    err_d    = fault_q;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            n_q      <= '0;
            p_q      <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            fault_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            n_q      <= n_d;
            p_q      <= p_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            fault_q  <= fault_d;
            err_q    <= err_d;
        end
    end

    assign result = result_q;
    assign err    = err_q;
    assign busy   = (state_q == CALC);
    assign done   = (state_q == DONE);

endmodule
